// File: rtl/player_input_sequencer.sv
// Per-player input sequencer: held-key levels to handshaked move/bomb requests.
// Last-pressed-wins direction with auto-repeat, edge-triggered bomb with cooldown.
module player_input_sequencer #(
    parameter int NUM_PLAYERS   = 2,
    parameter int REPEAT_DELAY  = 25_000_000,
    parameter int REPEAT_PERIOD = 10_000_000,
    parameter int BOMB_COOLDOWN = 50_000_000
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       game_active,
    input  logic [NUM_PLAYERS-1:0]     key_up,
    input  logic [NUM_PLAYERS-1:0]     key_down,
    input  logic [NUM_PLAYERS-1:0]     key_left,
    input  logic [NUM_PLAYERS-1:0]     key_right,
    input  logic [NUM_PLAYERS-1:0]     key_bomb,
    input  logic [NUM_PLAYERS-1:0]     move_ready,
    input  logic [NUM_PLAYERS-1:0]     bomb_ready,
    output logic [NUM_PLAYERS-1:0]     move_valid,
    output logic [2*NUM_PLAYERS-1:0]   move_dir,
    output logic [NUM_PLAYERS-1:0]     bomb_valid
);

    localparam int MAX_RP  = (REPEAT_DELAY > REPEAT_PERIOD) ?
                             REPEAT_DELAY : REPEAT_PERIOD;
    localparam int MAX_ALL = (MAX_RP > BOMB_COOLDOWN) ?
                             MAX_RP : BOMB_COOLDOWN;
    localparam int CW      = $clog2(MAX_ALL + 1);

    localparam logic [CW-1:0] DELAY_LOAD  = CW'(REPEAT_DELAY - 1);
    localparam logic [CW-1:0] PERIOD_LOAD = CW'(REPEAT_PERIOD - 1);
    localparam logic [CW-1:0] COOL_LOAD   = CW'(BOMB_COOLDOWN);
    localparam logic [CW-1:0] CNT_ONE     = CW'(1);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        DELAY  = 2'd1,
        REPEAT = 2'd2
    } state_t;

    // Key vector index equals direction code: up, down, left, right.
    function automatic logic [1:0] first_set(input logic [3:0] v);
        if (v[0])      return 2'd0;
        else if (v[1]) return 2'd1;
        else if (v[2]) return 2'd2;
        else           return 2'd3;
    endfunction

    genvar i;
    generate
        for (i = 0; i < NUM_PLAYERS; i++) begin : g_ch
            logic [3:0]    held;
            logic [3:0]    prev;
            logic [3:0]    press;
            logic          prev_bomb;
            logic          press_bomb;
            state_t        state;
            state_t        state_nx;
            logic [1:0]    dir;
            logic [1:0]    dir_nx;
            logic [CW-1:0] cnt;
            logic [CW-1:0] cnt_nx;
            logic          move_event;
            logic          mv;
            logic [1:0]    md;
            logic          bv;
            logic [CW-1:0] cool;

            assign held = {key_right[i], key_left[i],
                           key_down[i], key_up[i]};
            assign press      = held & ~prev;
            assign press_bomb = key_bomb[i] & ~prev_bomb;

            // Previous key samples; keep tracking even while inactive.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    prev      <= '0;
                    prev_bomb <= 1'b0;
                end else begin
                    prev      <= held;
                    prev_bomb <= key_bomb[i];
                end
            end

            // Repeat FSM state, current direction and repeat counter.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    state <= IDLE;
                    dir   <= 2'd0;
                    cnt   <= '0;
                end else begin
                    state <= state_nx;
                    dir   <= dir_nx;
                    cnt   <= cnt_nx;
                end
            end

            // Next state: newest press wins, else fall back or count down.
            always_comb begin
                state_nx = state;
                dir_nx   = dir;
                cnt_nx   = cnt;
                if (!game_active) begin
                    state_nx = IDLE;
                    cnt_nx   = '0;
                end else if (|press) begin
                    dir_nx   = first_set(press);
                    state_nx = DELAY;
                    cnt_nx   = DELAY_LOAD;
                end else if (state != IDLE) begin
                    if (!held[dir]) begin
                        if (|held) begin
                            dir_nx   = first_set(held);
                            state_nx = DELAY;
                            cnt_nx   = DELAY_LOAD;
                        end else begin
                            state_nx = IDLE;
                            cnt_nx   = '0;
                        end
                    end else if (cnt == '0) begin
                        state_nx = REPEAT;
                        cnt_nx   = PERIOD_LOAD;
                    end else begin
                        cnt_nx = cnt - CNT_ONE;
                    end
                end
            end

            // Move event: new direction, fallback, or repeat expiry.
            always_comb begin
                move_event = 1'b0;
                if (game_active) begin
                    if (|press) begin
                        move_event = 1'b1;
                    end else if (state != IDLE) begin
                        if (!held[dir]) move_event = |held;
                        else            move_event = (cnt == '0);
                    end
                end
            end

            // Single-entry move slot; a new event overwrites the direction.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    mv <= 1'b0;
                    md <= 2'd0;
                end else if (!game_active) begin
                    mv <= 1'b0;
                end else if (move_event) begin
                    mv <= 1'b1;
                    md <= dir_nx;
                end else if (mv && move_ready[i]) begin
                    mv <= 1'b0;
                end
            end

            // Bomb request with post-acceptance cooldown.
            always_ff @(posedge clock or negedge reset) begin
                if (!reset) begin
                    bv   <= 1'b0;
                    cool <= '0;
                end else if (!game_active) begin
                    bv   <= 1'b0;
                    cool <= '0;
                end else if (bv) begin
                    if (bomb_ready[i]) begin
                        bv   <= 1'b0;
                        cool <= COOL_LOAD;
                    end
                end else if (cool != '0) begin
                    cool <= cool - CNT_ONE;
                end else if (press_bomb) begin
                    bv <= 1'b1;
                end
            end

            assign move_valid[i]       = mv;
            assign move_dir[2*i +: 2]  = md;
            assign bomb_valid[i]       = bv;
        end
    endgenerate

endmodule

// File: tb/tb_player_input_sequencer.sv
// Directed bench for player_input_sequencer: vector table plus
// hand-written sequences for game_active flush and mid-run reset.
module tb_player_input_sequencer;

    logic       clock;
    logic       reset;
    logic       game_active;
    logic [1:0] key_up, key_down, key_left, key_right, key_bomb;
    logic [1:0] move_ready, bomb_ready;
    logic [1:0] move_valid;
    logic [3:0] move_dir;
    logic [1:0] bomb_valid;

    int tests = 0;
    int fails = 0;

    player_input_sequencer #(
        .NUM_PLAYERS   (2),
        .REPEAT_DELAY  (4),
        .REPEAT_PERIOD (2),
        .BOMB_COOLDOWN (3)
    ) dut (
        .clock       (clock),
        .reset       (reset),
        .game_active (game_active),
        .key_up      (key_up),
        .key_down    (key_down),
        .key_left    (key_left),
        .key_right   (key_right),
        .key_bomb    (key_bomb),
        .move_ready  (move_ready),
        .bomb_ready  (bomb_ready),
        .move_valid  (move_valid),
        .move_dir    (move_dir),
        .bomb_valid  (bomb_valid)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    typedef struct {
        string      name;
        logic [1:0] up, down, left, right, bomb;
        logic       ga;
        logic [1:0] mrdy, brdy;
        logic [1:0] mv;
        logic [3:0] md;
        logic [1:0] bv;
    } vec_t;

    vec_t vq[$];

    task automatic add(input string nm,
                       input logic [1:0] u, input logic [1:0] d,
                       input logic [1:0] l, input logic [1:0] r,
                       input logic [1:0] b, input logic ga,
                       input logic [1:0] mr, input logic [1:0] br,
                       input logic [1:0] mv, input logic [3:0] md,
                       input logic [1:0] bv);
        vec_t v;
        v.name = nm;
        v.up = u; v.down = d; v.left = l; v.right = r; v.bomb = b;
        v.ga = ga; v.mrdy = mr; v.brdy = br;
        v.mv = mv; v.md = md; v.bv = bv;
        vq.push_back(v);
    endtask

    task automatic drive(input logic [1:0] u, input logic [1:0] d,
                         input logic [1:0] l, input logic [1:0] r,
                         input logic [1:0] b, input logic ga,
                         input logic [1:0] mr, input logic [1:0] br);
        key_up = u; key_down = d; key_left = l; key_right = r;
        key_bomb = b; game_active = ga;
        move_ready = mr; bomb_ready = br;
    endtask

    task automatic check(input string nm, input logic [1:0] emv,
                         input logic [3:0] emd, input logic [1:0] ebv);
        tests++;
        if (move_valid !== emv || move_dir !== emd ||
            bomb_valid !== ebv) begin
            fails++;
            $display("FAIL %s: got mv=%b md=%b bv=%b, want mv=%b md=%b bv=%b",
                     nm, move_valid, move_dir, bomb_valid, emv, emd, ebv);
        end
    endtask

    task automatic step_check(input string nm, input logic [1:0] emv,
                              input logic [3:0] emd, input logic [1:0] ebv);
        @(posedge clock);
        #1;
        check(nm, emv, emd, ebv);
    endtask

    initial begin
        logic ev;
        // T1: P0 holds right 12 cycles; events at 0,4,6,8,10.
        for (int j = 0; j < 14; j++) begin
            ev = (j == 0 || j == 4 || j == 6 || j == 8 || j == 10);
            add($sformatf("t1_right[%0d]", j), 2'b00, 2'b00, 2'b00,
                (j < 12) ? 2'b01 : 2'b00, 2'b00, 1'b1, 2'b11, 2'b00,
                {1'b0, ev}, 4'b0011, 2'b00);
        end
        // T2: up held, left pressed at 2, released at 5; up released at 10.
        for (int j = 0; j < 11; j++) begin
            ev = (j == 0 || j == 2 || j == 5 || j == 9);
            add($sformatf("t2_fallback[%0d]", j),
                (j <= 9) ? 2'b01 : 2'b00, 2'b00,
                (j >= 2 && j <= 4) ? 2'b01 : 2'b00, 2'b00, 2'b00,
                1'b1, 2'b11, 2'b00, {1'b0, ev},
                (j >= 2 && j <= 4) ? 4'b0010 : 4'b0000, 2'b00);
        end
        // T3: P1 down then right with ready low; one ready cycle clears.
        add("t3_down",   2'b00, 2'b10, 2'b00, 2'b00, 2'b00, 1'b1,
            2'b00, 2'b00, 2'b10, 4'b0100, 2'b00);
        add("t3_right",  2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b1,
            2'b00, 2'b00, 2'b10, 4'b1100, 2'b00);
        add("t3_stall",  2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b1,
            2'b00, 2'b00, 2'b10, 4'b1100, 2'b00);
        add("t3_accept", 2'b00, 2'b10, 2'b00, 2'b10, 2'b00, 1'b1,
            2'b10, 2'b00, 2'b00, 4'b1100, 2'b00);
        add("t3_release", 2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1,
            2'b11, 2'b00, 2'b00, 4'b1100, 2'b00);
        // T4: bomb tap, accept, cooldown drop, re-tap, then long hold.
        for (int j = 0; j < 17; j++) begin
            add($sformatf("t4_bomb[%0d]", j), 2'b00, 2'b00, 2'b00, 2'b00,
                (j == 0 || j == 3 || (j >= 5 && j <= 15)) ? 2'b01 : 2'b00,
                1'b1, 2'b11, (j == 0) ? 2'b00 : 2'b11, 2'b00, 4'b1100,
                {1'b0, (j == 0 || j == 5)});
        end

        reset = 1'b0;
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b0, 2'b11, 2'b00);
        #1;
        check("reset_async", 2'b00, 4'b0000, 2'b00);
        step_check("reset_hold", 2'b00, 4'b0000, 2'b00);
        reset = 1'b1;
        game_active = 1'b1;
        step_check("idle", 2'b00, 4'b0000, 2'b00);

        for (int k = 0; k < vq.size(); k++) begin
            drive(vq[k].up, vq[k].down, vq[k].left, vq[k].right,
                  vq[k].bomb, vq[k].ga, vq[k].mrdy, vq[k].brdy);
            step_check(vq[k].name, vq[k].mv, vq[k].md, vq[k].bv);
        end

        // game_active low with keys held: nothing comes out.
        drive(2'b01, 2'b00, 2'b00, 2'b00, 2'b10, 1'b0, 2'b11, 2'b00);
        for (int j = 0; j < 3; j++)
            step_check("ga_low_held", 2'b00, 4'b1100, 2'b00);
        game_active = 1'b1;
        for (int j = 0; j < 3; j++)
            step_check("ga_rise_held", 2'b00, 4'b1100, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00);
        step_check("ga_release", 2'b00, 4'b1100, 2'b00);
        drive(2'b00, 2'b00, 2'b01, 2'b00, 2'b10, 1'b1, 2'b00, 2'b00);
        step_check("ga_repress", 2'b01, 4'b1110, 2'b10);
        game_active = 1'b0;
        step_check("ga_flush", 2'b00, 4'b1110, 2'b00);

        // Reset mid-repeat clears pending requests at once.
        drive(2'b00, 2'b00, 2'b00, 2'b00, 2'b00, 1'b1, 2'b00, 2'b00);
        step_check("rst_idle", 2'b00, 4'b1110, 2'b00);
        drive(2'b00, 2'b00, 2'b00, 2'b01, 2'b10, 1'b1, 2'b00, 2'b00);
        step_check("rst_press", 2'b01, 4'b1111, 2'b10);
        for (int j = 0; j < 3; j++)
            step_check("rst_hold", 2'b01, 4'b1111, 2'b10);
        #1;
        reset = 1'b0;
        #1;
        check("rst_mid", 2'b00, 4'b0000, 2'b00);
        @(negedge clock);
        reset = 1'b1;
        step_check("rst_held_press", 2'b01, 4'b0011, 2'b10);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
